// File: rtl/note_sequencer_pkg.sv
// Shared song-format definitions: FSM states, special note codes, ROM word fields.
package note_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_HOLD   = 3'd3,
    ST_PAUSED = 3'd4
  } state_t;

  localparam logic [4:0] NOTE_REST = 5'd0;
  localparam logic [4:0] NOTE_END  = 5'd31;

  localparam int NOTE_MSB = 7;
  localparam int NOTE_LSB = 3;
  localparam int DUR_MSB  = 2;
  localparam int DUR_LSB  = 0;

  // Note code field of a song ROM word.
  function automatic logic [4:0] rom_note(input logic [7:0] w);
    return w[NOTE_MSB:NOTE_LSB];
  endfunction

  // Duration code field of a song ROM word (beats minus one).
  function automatic logic [2:0] rom_dur(input logic [7:0] w);
    return w[DUR_MSB:DUR_LSB];
  endfunction

endpackage

// File: rtl/note_sequencer_counter_n.sv
// Modulo-N counter used as the beat prescaler; co flags the last count of each period.
module counter_n #(
  parameter int N            = 12_500_000,
  parameter int COUNTER_BITS = 24
) (
  input  logic                    clk,
  input  logic                    r,
  input  logic                    en,
  output logic [COUNTER_BITS-1:0] q,
  output logic                    co
);

  localparam logic [COUNTER_BITS-1:0] LAST = COUNTER_BITS'(N - 1);

  // Count while enabled, wrapping to zero after N-1; synchronous clear on r.
  always_ff @(posedge clk) begin
    if (r) begin
      q <= '0;
    end else if (en) begin
      q <= (q == LAST) ? '0 : q + COUNTER_BITS'(1);
    end
  end

  assign co = en && (q == LAST);

endmodule

// File: rtl/note_sequencer.sv
// Song playback controller: walks the song ROM, holds each note for its beat
// count and handles play / pause / stop / loop control.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int BEAT_DIV  = 12_500_000,
  parameter int BEAT_BITS = 24,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 r,
  input  logic                 play,
  input  logic                 pause,
  input  logic                 stop,
  input  logic                 loop,
  output logic [ADDR_BITS-1:0] rom_addr,
  input  logic [7:0]           rom_data,
  output logic [4:0]           note,
  output logic                 note_valid,
  output logic                 playing,
  output logic                 paused,
  output logic                 song_end
);

  state_t               state, state_nx;
  logic [ADDR_BITS-1:0] addr_nx;
  logic [4:0]           note_nx;
  logic [2:0]           beats_left, beats_nx;
  logic                 song_end_nx;

  logic [BEAT_BITS-1:0] beat_q;
  logic                 beat_co;
  logic                 pre_r;
  logic                 pre_en;

  // The prescaler restarts for every newly loaded note so each note gets whole beats;
  // it only runs while a note is actually sounding, which freezes it during pause.
  assign pre_r  = r | (state == ST_LOAD) | stop;
  assign pre_en = (state == ST_HOLD);

  counter_n #(
    .N            (BEAT_DIV),
    .COUNTER_BITS (BEAT_BITS)
  ) u_beat (
    .clk (clk),
    .r   (pre_r),
    .en  (pre_en),
    .q   (beat_q),
    .co  (beat_co)
  );

  // Next-state, address, note and beat-count decisions; stop overrides everything.
  always_comb begin
    state_nx    = state;
    addr_nx     = rom_addr;
    note_nx     = note;
    beats_nx    = beats_left;
    song_end_nx = 1'b0;

    if (stop && (state != ST_IDLE)) begin
      state_nx = ST_IDLE;
      addr_nx  = '0;
      note_nx  = NOTE_REST;
      beats_nx = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (play) state_nx = ST_FETCH;
        end
        ST_FETCH: begin
          state_nx = ST_LOAD;
        end
        ST_LOAD: begin
          if (rom_note(rom_data) == NOTE_END) begin
            addr_nx = '0;
            if (loop) begin
              state_nx = ST_FETCH;
            end else begin
              song_end_nx = 1'b1;
              state_nx    = ST_IDLE;
            end
          end else begin
            note_nx  = rom_note(rom_data);
            beats_nx = rom_dur(rom_data);
            state_nx = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (beat_co) begin
            if (beats_left != 3'd0) begin
              beats_nx = beats_left - 3'd1;
            end else if (!pause) begin
              // A pause landing on the final beat keeps the note; one more beat plays on resume.
              addr_nx  = rom_addr + ADDR_BITS'(1);
              state_nx = ST_FETCH;
            end
          end
          if (pause) state_nx = ST_PAUSED;
        end
        ST_PAUSED: begin
          if (play) state_nx = ST_HOLD;
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase
    end
  end

  // Register all control state and outputs; reset returns to an idle, silent player.
  always_ff @(posedge clk) begin
    if (r) begin
      state      <= ST_IDLE;
      rom_addr   <= '0;
      note       <= NOTE_REST;
      beats_left <= '0;
      song_end   <= 1'b0;
    end else begin
      state      <= state_nx;
      rom_addr   <= addr_nx;
      note       <= note_nx;
      beats_left <= beats_nx;
      song_end   <= song_end_nx;
    end
  end

  assign note_valid = (state == ST_HOLD) && (note != NOTE_REST) && (note != NOTE_END);
  assign playing    = (state == ST_FETCH) || (state == ST_LOAD) || (state == ST_HOLD);
  assign paused     = (state == ST_PAUSED);

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a 1-cycle behavioural ROM plus a note-schedule model
// built from song words (2 muted cycles per word, (d+1)*BEAT_DIV cycles per note).
module tb_note_sequencer;

  localparam int BD   = 4;
  localparam int AB   = 4;
  localparam int MAXC = 2048;

  logic          clk = 1'b0;
  logic          r, play, pause, stop, loop;
  logic [AB-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [4:0]    note;
  logic          note_valid, playing, paused, song_end;

  logic [7:0] rom [16];

  int errors = 0;
  int checks = 0;

  bit exp_play  [MAXC];
  bit exp_valid [MAXC];
  bit exp_end   [MAXC];
  int exp_note  [MAXC];
  int exp_addr  [MAXC];

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  note_sequencer #(
    .BEAT_DIV  (BD),
    .BEAT_BITS (3),
    .ADDR_BITS (AB)
  ) dut (
    .clk        (clk),
    .r          (r),
    .play       (play),
    .pause      (pause),
    .stop       (stop),
    .loop       (loop),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .note       (note),
    .note_valid (note_valid),
    .playing    (playing),
    .paused     (paused),
    .song_end   (song_end)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    play  = 1'b0;
    pause = 1'b0;
    stop  = 1'b0;
    r     = 1'b1;
    tick();
    tick();
    r = 1'b0;
  endtask

  task automatic load_demo_rom;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0] = 8'h1A;
    rom[1] = 8'h08;
    rom[2] = 8'hF8;
  endtask

  // Expected per-cycle trace after a play pulse at index 0, derived from the song words.
  task automatic build_model(input int ncyc, input bit lp);
    int j, addr, n, d;
    for (int i = 0; i < MAXC; i++) begin
      exp_play[i]  = 1'b0;
      exp_valid[i] = 1'b0;
      exp_end[i]   = 1'b0;
      exp_note[i]  = 0;
      exp_addr[i]  = 0;
    end
    j    = 1;
    addr = 0;
    while (j <= ncyc) begin
      exp_play[j] = 1'b1; exp_addr[j] = addr; j++;
      exp_play[j] = 1'b1; exp_addr[j] = addr; j++;
      n = int'(rom[addr][7:3]);
      d = int'(rom[addr][2:0]);
      if (n == 31) begin
        addr = 0;
        if (!lp) begin
          exp_end[j] = 1'b1;
          break;
        end
      end else begin
        for (int k = 0; k < (d + 1) * BD; k++) begin
          exp_play[j]  = 1'b1;
          exp_valid[j] = (n != 0);
          exp_note[j]  = n;
          exp_addr[j]  = addr;
          j++;
        end
        addr = (addr + 1) % 16;
      end
    end
  endtask

  // Play the current ROM from address 0 and compare every cycle against the model.
  task automatic test_song(input string tag, input int ncyc, input bit lp);
    do_reset();
    loop = lp;
    build_model(ncyc, lp);
    play = 1'b1;
    for (int j = 1; j <= ncyc; j++) begin
      tick();
      play = 1'b0;
      checks++;
      if (playing !== exp_play[j]) begin
        errors++;
        $display("FAIL %s playing cyc %0d: got %b want %b", tag, j, playing, exp_play[j]);
      end
      checks++;
      if (note_valid !== exp_valid[j]) begin
        errors++;
        $display("FAIL %s note_valid cyc %0d: got %b want %b", tag, j, note_valid, exp_valid[j]);
      end
      checks++;
      if (song_end !== exp_end[j]) begin
        errors++;
        $display("FAIL %s song_end cyc %0d: got %b want %b", tag, j, song_end, exp_end[j]);
      end
      checks++;
      if (paused !== 1'b0) begin
        errors++;
        $display("FAIL %s paused cyc %0d: got %b want 0", tag, j, paused);
      end
      checks++;
      if (int'(rom_addr) !== exp_addr[j]) begin
        errors++;
        $display("FAIL %s rom_addr cyc %0d: got %0d want %0d", tag, j, rom_addr, exp_addr[j]);
      end
      if (exp_valid[j]) begin
        checks++;
        if (int'(note) !== exp_note[j]) begin
          errors++;
          $display("FAIL %s note cyc %0d: got %0d want %0d", tag, j, note, exp_note[j]);
        end
      end
      if (errors > 60) break;
    end
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({rom_addr, note, note_valid, playing, paused, song_end} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got addr=%0d note=%0d nv=%b pl=%b pa=%b se=%b want all 0",
               rom_addr, note, note_valid, playing, paused, song_end);
    end
  endtask

  task automatic test_basic;
    load_demo_rom();
    test_song("basic", 40, 1'b0);
  endtask

  task automatic test_loop;
    load_demo_rom();
    test_song("loop", 120, 1'b1);
  endtask

  task automatic test_rest;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0] = 8'h03;
    rom[1] = 8'h10;
    rom[2] = 8'hF8;
    test_song("rest", 40, 1'b0);
  endtask

  // Pause after 'after' sounding cycles of note tgt for plen cycles; expect 'total' sounding cycles.
  task automatic test_pause(input string tag, input logic [4:0] tgt, input int after,
                            input int plen, input int total);
    int hc, guard;
    load_demo_rom();
    do_reset();
    loop  = 1'b0;
    hc    = 0;
    guard = 0;
    play  = 1'b1;
    while (hc < after && guard < 200) begin
      tick();
      play = 1'b0;
      guard++;
      if (note_valid && note == tgt) hc++;
    end
    checks++;
    if (hc != after) begin
      errors++;
      $display("FAIL %s reach note: got %0d sounding cycles want %0d", tag, hc, after);
    end
    pause = 1'b1;
    tick();
    pause = 1'b0;
    for (int i = 0; i < plen; i++) begin
      checks++;
      if (paused !== 1'b1 || note_valid !== 1'b0 || playing !== 1'b0) begin
        errors++;
        $display("FAIL %s paused cyc %0d: got pa=%b nv=%b pl=%b want 1 0 0",
                 tag, i, paused, note_valid, playing);
      end
      if (i == plen - 1) play = 1'b1;
      tick();
      play = 1'b0;
    end
    guard = 0;
    while (guard < 100) begin
      if (note_valid && note == tgt) hc++;
      else break;
      tick();
      guard++;
    end
    checks++;
    if (hc != total) begin
      errors++;
      $display("FAIL %s hold total: got %0d want %0d", tag, hc, total);
    end
  endtask

  task automatic test_stop;
    int guard;
    load_demo_rom();
    do_reset();
    loop  = 1'b0;
    guard = 0;
    play  = 1'b1;
    while (guard < 100) begin
      tick();
      play = 1'b0;
      guard++;
      if (note_valid && note == 5'd1) break;
    end
    checks++;
    if (rom_addr !== 4'd1) begin
      errors++;
      $display("FAIL stop pre-addr: got %0d want 1", rom_addr);
    end
    stop  = 1'b1;
    pause = 1'b1;
    tick();
    stop  = 1'b0;
    pause = 1'b0;
    checks++;
    if ({rom_addr, note, note_valid, playing, paused, song_end} !== '0) begin
      errors++;
      $display("FAIL stop idle: got addr=%0d note=%0d nv=%b pl=%b pa=%b se=%b want all 0",
               rom_addr, note, note_valid, playing, paused, song_end);
    end
    play = 1'b1;
    tick();
    play = 1'b0;
    tick();
    tick();
    checks++;
    if (note_valid !== 1'b1 || note !== 5'd3 || rom_addr !== 4'd0) begin
      errors++;
      $display("FAIL stop restart: got nv=%b note=%0d addr=%0d want 1 3 0", note_valid, note, rom_addr);
    end
  endtask

  task automatic test_wrap;
    int guard;
    for (int i = 0; i < 16; i++) rom[i] = {5'(i + 1), 3'd0};
    test_song("wrap", 150, 1'b0);
    guard = 0;
    while (!note_valid && guard < 20) begin
      tick();
      guard++;
    end
    r = 1'b1;
    tick();
    r = 1'b0;
    checks++;
    if ({rom_addr, note, note_valid, playing, paused, song_end} !== '0) begin
      errors++;
      $display("FAIL wrap reset: got addr=%0d note=%0d nv=%b pl=%b pa=%b se=%b want all 0",
               rom_addr, note, note_valid, playing, paused, song_end);
    end
  endtask

  task automatic test_random;
    int pos;
    bit lp;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 4) == 0) rom[i] = {5'd0, 3'($urandom_range(0, 7))};
        else rom[i] = {5'($urandom_range(1, 30)), 3'($urandom_range(0, 7))};
      end
      pos = int'($urandom_range(1, 20));
      if (pos < 16) rom[pos] = 8'hF8;
      lp = 1'($urandom_range(0, 1));
      test_song("random", 400, lp);
    end
  endtask

  initial begin
    r     = 1'b1;
    play  = 1'b0;
    pause = 1'b0;
    stop  = 1'b0;
    loop  = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    test_reset();
    test_basic();
    test_loop();
    test_rest();
    test_pause("pause_mid", 5'd3, 5, 20, 12);
    test_pause("pause_final", 5'd1, 4, 7, 8);
    test_stop();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
